// File: rtl/hud_digits_renderer.sv
// HUD digit renderer: per-frame BCD snapshot, 8x16 glyphs scaled 2x.
// Two-stage pixel pipeline into the VGA object mux.
`timescale 1ns/1ps
module hud_digits_renderer #(
    parameter int SCORE_X = 16,
    parameter int SPEED_X = 128,
    parameter int FUEL_X  = 224,
    parameter int TOP_Y   = 8
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        onesec,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic [3:0]  scoreMMsb,
    input  logic [3:0]  scoreMLsb,
    input  logic [3:0]  scoreLMsb,
    input  logic [4:0]  scoreLLsb,
    input  logic [3:0]  speedMsb,
    input  logic [3:0]  speedMidb,
    input  logic [3:0]  speedLsb,
    input  logic [3:0]  fuelMsb,
    input  logic [3:0]  fuelLsb,
    input  logic        fuel_zero,
    input  logic        win,
    output logic        drawingRequest,
    output logic [7:0]  RGBout
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    localparam logic [4:0]  BLANK  = 5'h1F;
    localparam logic [7:0]  C_WHT  = 8'hFF;
    localparam logic [7:0]  C_RED  = 8'hE0;
    localparam logic [7:0]  C_WIN  = 8'hFC;

    localparam logic [10:0] L_SX  = 11'(SCORE_X);
    localparam logic [10:0] L_SXE = 11'(SCORE_X + 64);
    localparam logic [10:0] L_PX  = 11'(SPEED_X);
    localparam logic [10:0] L_PXE = 11'(SPEED_X + 48);
    localparam logic [10:0] L_FX  = 11'(FUEL_X);
    localparam logic [10:0] L_FXE = 11'(FUEL_X + 32);
    localparam logic [10:0] L_Y   = 11'(TOP_Y);
    localparam logic [10:0] L_YE  = 11'(TOP_Y + 32);

    // Glyph rows packed MSB-first: row 0 in bits [127:120], bit 7 = left column.
    function automatic logic glyph_bit(
        input logic [4:0] d,
        input logic [3:0] row,
        input logic [2:0] col
    );
        logic [127:0] g;
        logic [6:0]   k;
        g = '0;
        case (d)
            5'd0: g = 128'h0000_3C66_666E_7666_6666_6666_663C_0000;
            5'd1: g = 128'h0000_1838_7818_1818_1818_1818_187E_0000;
            5'd2: g = 128'h0000_3C66_6606_0C18_3060_6066_7E7E_0000;
            5'd3: g = 128'h0000_3C66_0606_1C06_0606_0666_663C_0000;
            5'd4: g = 128'h0000_0C1C_3C6C_CCCC_FE0C_0C0C_0C1E_0000;
            5'd5: g = 128'h0000_7E60_6060_7C06_0606_0666_663C_0000;
            5'd6: g = 128'h0000_3C66_6060_7C66_6666_6666_663C_0000;
            5'd7: g = 128'h0000_7E66_0606_0C18_1818_1818_1818_0000;
            5'd8: g = 128'h0000_3C66_6666_3C66_6666_6666_663C_0000;
            5'd9: g = 128'h0000_3C66_6666_663E_0606_0606_663C_0000;
            default: g = '0;
        endcase
        k = ~{row, col};
        return g[k];
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;

    logic [3:0]  r_sc0, r_sc1, r_sc2;
    logic [4:0]  r_sc3;
    logic [3:0]  r_sp0, r_sp1, r_sp2;
    logic [3:0]  r_fu0, r_fu1;
    logic        r_fz, r_win;
    logic        r_blink;

    logic        r_hit;
    logic [4:0]  r_dig;
    logic [3:0]  r_row;
    logic [2:0]  r_col;
    logic [7:0]  r_rgb;

    logic        w_yin, w_hs, w_hp, w_hf;
    logic [1:0]  w_sidx, w_pidx;
    logic        w_fidx;
    logic [2:0]  w_scol, w_pcol, w_fcol;
    logic [3:0]  w_row;
    logic        w_low;
    logic        w_bs0, w_bs1, w_bs2;
    logic        w_bp0, w_bp1;
    logic        w_hit;
    logic [4:0]  w_dig;
    logic [2:0]  w_col;
    logic [7:0]  w_rgb;
    logic        w_on;

    assign w_yin  = (pixelY >= L_Y) && (pixelY < L_YE);
    assign w_hs   = w_yin && (pixelX >= L_SX) && (pixelX < L_SXE);
    assign w_hp   = w_yin && (pixelX >= L_PX) && (pixelX < L_PXE);
    assign w_hf   = w_yin && (pixelX >= L_FX) && (pixelX < L_FXE);

    assign w_sidx = 2'((pixelX - L_SX) >> 4);
    assign w_pidx = 2'((pixelX - L_PX) >> 4);
    assign w_fidx = 1'((pixelX - L_FX) >> 4);
    assign w_scol = 3'((pixelX - L_SX) >> 1);
    assign w_pcol = 3'((pixelX - L_PX) >> 1);
    assign w_fcol = 3'((pixelX - L_FX) >> 1);
    assign w_row  = 4'((pixelY - L_Y) >> 1);

    assign w_low  = (r_fu0 < 4'd2) && !r_fz;

    // Leading zeros: blank while this and all higher digits are zero.
    assign w_bs0  = (r_sc0 == 4'd0);
    assign w_bs1  = w_bs0 && (r_sc1 == 4'd0);
    assign w_bs2  = w_bs1 && (r_sc2 == 4'd0);
    assign w_bp0  = (r_sp0 == 4'd0);
    assign w_bp1  = w_bp0 && (r_sp1 == 4'd0);

    // Frame-state register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Leave IDLE on the first frame start, then stay active.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (startOfFrame) w_state_nxt = ACTIVE;
            ACTIVE:  w_state_nxt = ACTIVE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Shadow copy of the digits, taken once per frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_sc0 <= '0; r_sc1 <= '0; r_sc2 <= '0; r_sc3 <= '0;
            r_sp0 <= '0; r_sp1 <= '0; r_sp2 <= '0;
            r_fu0 <= '0; r_fu1 <= '0;
            r_fz  <= 1'b0;
            r_win <= 1'b0;
        end else if (startOfFrame) begin
            r_sc0 <= scoreMMsb; r_sc1 <= scoreMLsb;
            r_sc2 <= scoreLMsb; r_sc3 <= scoreLLsb;
            r_sp0 <= speedMsb;  r_sp1 <= speedMidb;
            r_sp2 <= speedLsb;
            r_fu0 <= fuelMsb;   r_fu1 <= fuelLsb;
            r_fz  <= fuel_zero;
            r_win <= win;
        end
    end

    // Low-fuel blink phase: toggles each second, parked visible otherwise.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)     r_blink <= 1'b1;
        else if (!w_low) r_blink <= 1'b1;
        else if (onesec) r_blink <= ~r_blink;
    end

    // Field decode: pick digit, column and colour for this pixel.
    always_comb begin
        w_hit = 1'b0;
        w_dig = BLANK;
        w_col = 3'd0;
        w_rgb = C_WHT;
        unique case (1'b1)
            w_hs: begin
                w_hit = 1'b1;
                w_col = w_scol;
                unique case (w_sidx)
                    2'd0: w_dig = w_bs0 ? BLANK : {1'b0, r_sc0};
                    2'd1: w_dig = w_bs1 ? BLANK : {1'b0, r_sc1};
                    2'd2: w_dig = w_bs2 ? BLANK : {1'b0, r_sc2};
                    default: w_dig = r_sc3;
                endcase
            end
            w_hp: begin
                w_hit = 1'b1;
                w_col = w_pcol;
                unique case (w_pidx)
                    2'd0: w_dig = w_bp0 ? BLANK : {1'b0, r_sp0};
                    2'd1: w_dig = w_bp1 ? BLANK : {1'b0, r_sp1};
                    2'd2: w_dig = {1'b0, r_sp2};
                    default: w_dig = BLANK;
                endcase
            end
            w_hf: begin
                w_hit = r_blink;
                w_col = w_fcol;
                w_dig = w_fidx ? {1'b0, r_fu1} : {1'b0, r_fu0};
                if (w_low || r_fz) w_rgb = C_RED;
            end
            default: w_hit = 1'b0;
        endcase
        if (r_win) w_rgb = C_WIN;
    end

    // Stage 1: register the decoded pixel context.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_hit <= 1'b0;
            r_dig <= BLANK;
            r_row <= '0;
            r_col <= '0;
            r_rgb <= '0;
        end else begin
            r_hit <= w_hit;
            r_dig <= w_dig;
            r_row <= w_row;
            r_col <= w_col;
            r_rgb <= w_rgb;
        end
    end

    assign w_on = r_hit && (r_state == ACTIVE) &&
                  glyph_bit(r_dig, r_row, r_col);

    // Stage 2: glyph lookup into the mux outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            drawingRequest <= 1'b0;
            RGBout         <= 8'h00;
        end else begin
            drawingRequest <= w_on;
            RGBout         <= w_on ? r_rgb : 8'h00;
        end
    end

endmodule

// File: tb/tb_hud_digits_renderer.sv
// Directed bench for hud_digits_renderer.
// Glyph bitmaps below are the hand-drawn reference font.
`timescale 1ns/1ps
module tb_hud_digits_renderer;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        onesec = 1'b0;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic [3:0]  scoreMMsb = 4'd0;
    logic [3:0]  scoreMLsb = 4'd0;
    logic [3:0]  scoreLMsb = 4'd1;
    logic [4:0]  scoreLLsb = 5'd2;
    logic [3:0]  speedMsb = 4'd0;
    logic [3:0]  speedMidb = 4'd0;
    logic [3:0]  speedLsb = 4'd0;
    logic [3:0]  fuelMsb = 4'd5;
    logic [3:0]  fuelLsb = 4'd0;
    logic        fuel_zero = 1'b0;
    logic        win = 1'b0;
    logic        drawingRequest;
    logic [7:0]  RGBout;

    int total = 0;
    int bad = 0;
    int idx;
    int d;
    logic e;

    localparam logic [127:0] T [0:9] = '{
        128'h0000_3C66_666E_7666_6666_6666_663C_0000,
        128'h0000_1838_7818_1818_1818_1818_187E_0000,
        128'h0000_3C66_6606_0C18_3060_6066_7E7E_0000,
        128'h0000_3C66_0606_1C06_0606_0666_663C_0000,
        128'h0000_0C1C_3C6C_CCCC_FE0C_0C0C_0C1E_0000,
        128'h0000_7E60_6060_7C06_0606_0666_663C_0000,
        128'h0000_3C66_6060_7C66_6666_6666_663C_0000,
        128'h0000_7E66_0606_0C18_1818_1818_1818_0000,
        128'h0000_3C66_6666_3C66_6666_6666_663C_0000,
        128'h0000_3C66_6666_663E_0606_0606_663C_0000
    };

    hud_digits_renderer dut (
        .clk(clk), .resetN(resetN),
        .startOfFrame(startOfFrame), .onesec(onesec),
        .pixelX(pixelX), .pixelY(pixelY),
        .scoreMMsb(scoreMMsb), .scoreMLsb(scoreMLsb),
        .scoreLMsb(scoreLMsb), .scoreLLsb(scoreLLsb),
        .speedMsb(speedMsb), .speedMidb(speedMidb),
        .speedLsb(speedLsb),
        .fuelMsb(fuelMsb), .fuelLsb(fuelLsb),
        .fuel_zero(fuel_zero), .win(win),
        .drawingRequest(drawingRequest), .RGBout(RGBout)
    );

    always #5 clk = ~clk;

    function automatic logic gb(input int dg, input int r, input int c);
        logic [127:0] g;
        g = T[dg];
        return g[127 - r * 8 - c];
    endfunction

    task automatic check(input logic [8:0] got, input logic [8:0] exp,
                         input string tag);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s dr/rgb got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic probe(input int x, input int y, input logic ex,
                         input logic [7:0] c, input string tag);
        pixelX = 11'(x);
        pixelY = 11'(y);
        @(posedge clk); @(posedge clk); #1;
        total++;
        assert ({drawingRequest, RGBout} === {ex, ex ? c : 8'h00}) else begin
            bad++;
            $error("FAIL %s x=%0d y=%0d got dr=%0b rgb=%h want dr=%0b rgb=%h",
                   tag, x, y, drawingRequest, RGBout, ex, ex ? c : 8'h00);
        end
    endtask

    task automatic snap();
        startOfFrame = 1'b1;
        @(posedge clk); #1;
        startOfFrame = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_sec();
        onesec = 1'b1;
        @(posedge clk); #1;
        onesec = 1'b0;
    endtask

    initial begin
        #1;
        check({drawingRequest, RGBout}, 9'h000, "reset_out");
        repeat (3) @(posedge clk);
        #1;
        resetN = 1'b1;
        @(posedge clk); #1;

        // 1: idle, no frame start yet
        probe(20, 10, 1'b0, 8'h00, "idle_20_10");
        probe(68, 12, 1'b0, 8'h00, "idle_68_12");
        repeat (5) @(posedge clk);
        #1;
        probe(20, 10, 1'b0, 8'h00, "idle_late");

        // 2: score 0012
        snap();
        for (int y = 8; y < 40; y++) begin
            for (int x = 16; x < 80; x++) begin
                idx = (x - 16) / 16;
                d = (idx == 2) ? 1 : (idx == 3) ? 2 : -1;
                e = (d >= 0) && gb(d, (y - 8) / 2, ((x - 16) % 16) / 2);
                probe(x, y, e, 8'hFF, "score_scan");
            end
        end
        probe(164, 12, 1'b1, 8'hFF, "speed_lsb_zero");
        probe(148, 12, 1'b0, 8'h00, "speed_lead_blank");
        probe(226, 12, 1'b1, 8'hFF, "fuel_normal");
        probe(80, 12, 1'b0, 8'h00, "gap_right");

        // 3: mid-frame change is not seen
        scoreMMsb = 4'd9; scoreMLsb = 4'd9;
        scoreLMsb = 4'd9; scoreLLsb = 5'd9;
        probe(20, 12, 1'b0, 8'h00, "tear_idx0");
        probe(54, 12, 1'b1, 8'hFF, "tear_idx2");
        probe(68, 12, 1'b1, 8'hFF, "tear_idx3");
        scoreLLsb = 5'd12;
        snap();
        probe(20, 12, 1'b1, 8'hFF, "nine_idx0");
        probe(36, 12, 1'b1, 8'hFF, "nine_idx1");
        probe(68, 12, 1'b0, 8'h00, "llsb12_blank");

        // 4: latency in and out of a lit bit
        pixelX = 11'd16; pixelY = 11'd12;
        repeat (3) @(posedge clk);
        #1;
        pixelX = 11'd20;
        @(posedge clk); #1;
        check({drawingRequest, RGBout}, 9'h000, "lat_in_1");
        @(posedge clk); #1;
        check({drawingRequest, RGBout}, 9'h1FF, "lat_in_2");
        pixelX = 11'd16;
        @(posedge clk); #1;
        check({drawingRequest, RGBout}, 9'h1FF, "lat_out_1");
        @(posedge clk); #1;
        check({drawingRequest, RGBout}, 9'h000, "lat_out_2");

        // 5: low fuel blink, then fuel_zero
        fuelMsb = 4'd1; fuelLsb = 4'd5;
        snap();
        probe(230, 12, 1'b1, 8'hE0, "low_vis_1");
        probe(242, 12, 1'b1, 8'hE0, "low_vis_5");
        probe(20, 12, 1'b1, 8'hFF, "low_score_wht");
        pulse_sec();
        probe(230, 12, 1'b0, 8'h00, "blink_hid_a");
        probe(242, 12, 1'b0, 8'h00, "blink_hid_b");
        pulse_sec();
        probe(230, 12, 1'b1, 8'hE0, "blink_vis");
        pulse_sec();
        probe(230, 12, 1'b0, 8'h00, "blink_hid_c");
        fuelMsb = 4'd0; fuelLsb = 4'd0; fuel_zero = 1'b1;
        snap();
        probe(228, 12, 1'b1, 8'hE0, "fz_msd");
        probe(244, 12, 1'b1, 8'hE0, "fz_lsd");
        pulse_sec();
        probe(228, 12, 1'b1, 8'hE0, "fz_steady");

        // 6: win colour, then async reset
        fuel_zero = 1'b0; fuelMsb = 4'd5; fuelLsb = 4'd0;
        speedMsb = 4'd0; speedMidb = 4'd0; speedLsb = 4'd7;
        win = 1'b1;
        snap();
        probe(20, 12, 1'b1, 8'hFC, "win_score");
        probe(226, 12, 1'b1, 8'hFC, "win_fuel_5");
        probe(244, 12, 1'b1, 8'hFC, "win_fuel_0");
        probe(162, 12, 1'b1, 8'hFC, "win_speed_7");
        probe(148, 12, 1'b0, 8'h00, "win_speed_blank");
        probe(20, 12, 1'b1, 8'hFC, "pre_reset");
        resetN = 1'b0;
        #1;
        check({drawingRequest, RGBout}, 9'h000, "async_reset");
        @(posedge clk); #1;
        resetN = 1'b1;
        probe(20, 12, 1'b0, 8'h00, "post_reset_a");
        probe(68, 12, 1'b0, 8'h00, "post_reset_b");
        snap();
        probe(20, 12, 1'b1, 8'hFC, "resume");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
